t09_obstacle_placer: RTL
========================

# t09_obstacle_placer

Consumes the coordinates from the obstacle random generator and turns them into committed obstacles on the 14×10 playfield (X 1..14, Y 1..10). On each placement request it tests candidate cells against the snake body, the head keep-out zone, the apple and existing obstacles. It pulses `obstacleFlag` back to the generator to advance the sequence, stores up to `MAX_OBS` obstacles, and answers combinational "is obstacle here" lookups for the collision and display logic.

## Interface
- `MAX_OBS`, 8: obstacle slots; must be a power of two, 2..16.
- `MAX_TRIES`, 8: candidate attempts per request before giving up.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `place_req` in 1: one-cycle request to place one obstacle.
- `clear` in 1: synchronous wipe of all obstacles.
- `randX`, `randY`, `randX2`, `randY2` in 4 each: candidate pairs A and B from the generator.
- `headX`, `headY` in 4 each: snake head cell.
- `appleX`, `appleY` in 4 each: apple cell.
- `query_x`, `query_y` out 4 each: body-occupancy query address.
- `query_en` out 1: query strobe.
- `query_hit` in 1: body occupies the queried cell; valid the cycle after `query_en`.
- `chkX`, `chkY` in 4 each: lookup cell.
- `obs_hit` out 1: combinational; a valid slot matches (`chkX`, `chkY`).
- `obstacleFlag` out 1: registered pulse that advances the generator.
- `busy` out 1: FSM is not in IDLE.
- `done` out 1: one-cycle pulse when an obstacle is committed.
- `fail` out 1: one-cycle pulse when a request is dropped.
- `obs_count` out clog2(MAX_OBS)+1: number of valid obstacles.

## Operation
- States: IDLE, LOAD, QUERY, WAIT, CHECK, COMMIT, RETRY.
- IDLE → LOAD on `place_req` when `obs_count < MAX_OBS`.
  - If full, stay in IDLE and pulse `fail` on the next cycle.
  - `place_req` while `busy` is ignored and not queued.
- LOAD: latch the candidate into `cand_x`/`cand_y`.
  - Even attempt index uses (`randX`, `randY`); odd uses (`randX2`, `randY2`).
- QUERY: drive `query_x`/`query_y` = candidate; `query_en` = 1 for exactly this cycle.
- WAIT: sample `query_hit`.
- CHECK: reject the candidate if any of the following holds:
  - body hit;
  - `|cand-head| ≤ 1` on both axes (3×3 keep-out);
  - candidate equals the apple;
  - candidate matches an existing obstacle;
  - X outside 1..14 or Y outside 1..10.
- CHECK outcome:
  - Pass → COMMIT.
  - Fail with tries < `MAX_TRIES` → RETRY.
  - Fail with tries = `MAX_TRIES` → IDLE with `fail` pulse.
- COMMIT: write slot[`obs_count`], increment the count, pulse `done` and `obstacleFlag`, → IDLE.
- RETRY: pulse `obstacleFlag`, increment the try counter, → LOAD.
- `clear`: all slots invalid, `obs_count` = 0, FSM → IDLE, no pulses, in-flight request dropped. `rst` has priority over `clear`; `clear` has priority over everything else.
- Arithmetic:
  - Distance uses 5-bit signed differences, so there is no wrap.
  - Try counter is 4-bit and saturates.

## Timing
- Reset values:
  - State IDLE.
  - `obstacleFlag`, `done`, `fail`, `busy`, `query_en` = 0.
  - `query_x`, `query_y` = 0.
  - `obs_count` = 0; all slots invalid (coordinates 0).
- Success on the first attempt:
  - `place_req` at cycle 0.
  - LOAD cycle 1, QUERY 2, WAIT 3, CHECK 4.
  - `done` and `obstacleFlag` high in cycle 5.
  - `obs_count` and `obs_hit` updated from cycle 6.
- Each retry adds 5 cycles (RETRY, LOAD, QUERY, WAIT, CHECK); the generator advances in the RETRY cycle.
- Worst case: 5 + 5·(`MAX_TRIES`−1) cycles to a `fail` pulse.
- `done` and `fail` are never high in the same cycle.
- `obs_hit` has zero latency from `chkX`/`chkY` and reflects only committed slots.
- `rst` or `clear` mid-operation takes effect on the next edge; no partial commit.

## Structure
- Package `t09_obstacle_pkg` holds:
  - `GRID_X_MIN/MAX` (1/14) and `GRID_Y_MIN/MAX` (1/10);
  - the `placer_state_t` enum;
  - a `cell_t` struct {x[3:0], y[3:0]}.
- Sub-module `t09_obstacle_store` is the slot register file with write port, valid bits, count and two match ports.
  - One match port is the duplicate check in CHECK.
  - The other is the external `obs_hit` lookup.
- `t09_obstacle_placer` holds only the FSM, try counter and candidate checks.

## Test plan
- Reset, then `place_req` with A=(8,2), head (3,3), apple (5,5), `query_hit`=0 → `done` at cycle 5; `obs_count`=1; `chk`=(8,2) gives `obs_hit`=1.
- A=(4,4) with head (3,3) → RETRY with `obstacleFlag` pulse. B=(3,4)... must also be rejected, so use B=(10,7) → second attempt commits (10,7); `done` at cycle 10.
- `query_hit`=1 on every query → 8 attempts, 7 `obstacleFlag` pulses, `fail` at cycle 40, `obs_count` unchanged.
- Fill 8 slots, then `place_req` → `fail` next cycle, `busy` stays 0, `obs_count`=8.
- Candidate equal to an existing obstacle or to the apple, then A=(15,3) → each rejected; commit happens only on a legal cell.
- Assert `clear` during WAIT → IDLE next cycle; `obs_count`=0; no `done`; `obs_hit`=0 for all cells.

Source files
------------

// File: rtl/t09_obstacle_pkg.sv
// Shared playfield bounds, placer FSM states and the packed cell type
// used by the obstacle placer and its slot store.
package t09_obstacle_pkg;

  localparam logic [3:0] GRID_X_MIN = 4'd1;
  localparam logic [3:0] GRID_X_MAX = 4'd14;
  localparam logic [3:0] GRID_Y_MIN = 4'd1;
  localparam logic [3:0] GRID_Y_MAX = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_QUERY,
    ST_WAIT,
    ST_CHECK,
    ST_COMMIT,
    ST_RETRY
  } placer_state_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } cell_t;

endpackage

// File: rtl/t09_obstacle_store.sv
// Obstacle slot register file: append-only write at slot[count], valid bits,
// and two combinational match ports (duplicate check and external lookup).
module t09_obstacle_store
  import t09_obstacle_pkg::*;
#(
  parameter int MAX_OBS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_en,
  input  cell_t                    wr_cell,
  input  cell_t                    dup_cell,
  output logic                     dup_hit,
  input  cell_t                    look_cell,
  output logic                     look_hit,
  output logic [$clog2(MAX_OBS):0] count
);

  localparam int IDX_W = $clog2(MAX_OBS);

  logic [IDX_W:0]     count_reg;
  logic               wr_ok;
  logic [MAX_OBS-1:0] dup_vec;
  logic [MAX_OBS-1:0] look_vec;

  // MAX_OBS is a power of two, so the count MSB alone means "full".
  assign wr_ok = wr_en && !count_reg[IDX_W];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (wr_ok) begin
      count_reg <= count_reg + {{IDX_W{1'b0}}, 1'b1};
    end
  end

  generate
    for (genvar gi = 0; gi < MAX_OBS; gi++) begin : g_slot
      logic  valid_reg;
      cell_t slot_reg;

      always_ff @(posedge clk) begin
        if (rst || clear) begin
          valid_reg <= 1'b0;
          slot_reg  <= '0;
        end else if (wr_ok && (count_reg[IDX_W-1:0] == IDX_W'(gi))) begin
          valid_reg <= 1'b1;
          slot_reg  <= wr_cell;
        end
      end

      assign dup_vec[gi]  = valid_reg && (slot_reg == dup_cell);
      assign look_vec[gi] = valid_reg && (slot_reg == look_cell);
    end
  endgenerate

  assign dup_hit  = |dup_vec;
  assign look_hit = |look_vec;
  assign count    = count_reg;

endmodule

// File: rtl/t09_obstacle_placer.sv
// Obstacle placement FSM: fetches candidates from the generator, vets them
// against body, head zone, apple and existing obstacles, and commits one.
module t09_obstacle_placer
  import t09_obstacle_pkg::*;
#(
  parameter int MAX_OBS   = 8,
  parameter int MAX_TRIES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     place_req,
  input  logic                     clear,
  input  logic [3:0]               randX,
  input  logic [3:0]               randY,
  input  logic [3:0]               randX2,
  input  logic [3:0]               randY2,
  input  logic [3:0]               headX,
  input  logic [3:0]               headY,
  input  logic [3:0]               appleX,
  input  logic [3:0]               appleY,
  output logic [3:0]               query_x,
  output logic [3:0]               query_y,
  output logic                     query_en,
  input  logic                     query_hit,
  input  logic [3:0]               chkX,
  input  logic [3:0]               chkY,
  output logic                     obs_hit,
  output logic                     obstacleFlag,
  output logic                     busy,
  output logic                     done,
  output logic                     fail,
  output logic [$clog2(MAX_OBS):0] obs_count
);

  localparam int         CNT_W     = $clog2(MAX_OBS) + 1;
  localparam logic [3:0] TRIES_LIM = 4'(MAX_TRIES);

  placer_state_t     state_reg, state_next;
  cell_t             cand_reg, cand_next;
  logic [3:0]        try_reg, try_next;
  logic              hit_reg, hit_next;
  logic              done_reg, done_next;
  logic              flag_reg, flag_next;
  logic              fail_reg, fail_next;
  logic              commit_en;
  logic              dup_hit;
  logic              full;
  logic signed [4:0] dx, dy;
  logic              near_head, is_apple, off_grid, reject;
  cell_t             chk_cell;

  assign chk_cell = {chkX, chkY};

  t09_obstacle_store #(.MAX_OBS(MAX_OBS)) u_store (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .wr_en     (commit_en),
    .wr_cell   (cand_reg),
    .dup_cell  (cand_reg),
    .dup_hit   (dup_hit),
    .look_cell (chk_cell),
    .look_hit  (obs_hit),
    .count     (obs_count)
  );

  assign full = obs_count[CNT_W-1];

  // Zero-extended signed differences so head-zone distance never wraps.
  assign dx        = $signed({1'b0, cand_reg.x}) - $signed({1'b0, headX});
  assign dy        = $signed({1'b0, cand_reg.y}) - $signed({1'b0, headY});
  assign near_head = (dx >= -5'sd1) && (dx <= 5'sd1) && (dy >= -5'sd1) && (dy <= 5'sd1);
  assign is_apple  = (cand_reg.x == appleX) && (cand_reg.y == appleY);
  assign off_grid  = (cand_reg.x < GRID_X_MIN) || (cand_reg.x > GRID_X_MAX) ||
                     (cand_reg.y < GRID_Y_MIN) || (cand_reg.y > GRID_Y_MAX);
  assign reject    = hit_reg || near_head || is_apple || dup_hit || off_grid;

  always_comb begin
    state_next = state_reg;
    cand_next  = cand_reg;
    try_next   = try_reg;
    hit_next   = hit_reg;
    done_next  = 1'b0;
    flag_next  = 1'b0;
    fail_next  = 1'b0;
    commit_en  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (place_req) begin
          if (full) begin
            fail_next = 1'b1;
          end else begin
            state_next = ST_LOAD;
            try_next   = 4'd1;
          end
        end
      end
      // try_reg counts attempts from 1, so odd values are even attempt indices.
      ST_LOAD: begin
        cand_next  = try_reg[0] ? {randX, randY} : {randX2, randY2};
        state_next = ST_QUERY;
      end
      ST_QUERY: state_next = ST_WAIT;
      ST_WAIT: begin
        hit_next   = query_hit;
        state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (!reject) begin
          state_next = ST_COMMIT;
          done_next  = 1'b1;
          flag_next  = 1'b1;
        end else if (try_reg < TRIES_LIM) begin
          state_next = ST_RETRY;
          flag_next  = 1'b1;
        end else begin
          state_next = ST_IDLE;
          fail_next  = 1'b1;
        end
      end
      ST_COMMIT: begin
        commit_en  = 1'b1;
        state_next = ST_IDLE;
      end
      ST_RETRY: begin
        try_next   = (try_reg == 4'hF) ? try_reg : try_reg + 4'd1;
        state_next = ST_LOAD;
      end
      default: state_next = ST_IDLE;
    endcase
    if (clear) begin
      state_next = ST_IDLE;
      done_next  = 1'b0;
      flag_next  = 1'b0;
      fail_next  = 1'b0;
      commit_en  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cand_reg  <= '0;
      try_reg   <= '0;
      hit_reg   <= 1'b0;
      done_reg  <= 1'b0;
      flag_reg  <= 1'b0;
      fail_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cand_reg  <= cand_next;
      try_reg   <= try_next;
      hit_reg   <= hit_next;
      done_reg  <= done_next;
      flag_reg  <= flag_next;
      fail_reg  <= fail_next;
    end
  end

  assign busy         = (state_reg != ST_IDLE);
  assign query_en     = (state_reg == ST_QUERY);
  assign query_x      = query_en ? cand_reg.x : 4'd0;
  assign query_y      = query_en ? cand_reg.y : 4'd0;
  assign done         = done_reg;
  assign fail         = fail_reg;
  assign obstacleFlag = flag_reg;

endmodule
